// File: rtl/decoder_iteration_scheduler.sv
// Iteration sequencer for the min-sum decoder: VN -> CN per iteration,
// then the output layer, with early termination, abort and a layer watchdog.
module decoder_iteration_scheduler #(
    parameter int MAX_ITER   = 5,
    parameter int ITER_W     = 3,
    parameter bit EARLY_TERM = 1'b1,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              varn_ready,
    input  logic              checkn_ready,
    input  logic              syndrome_ok,
    input  logic              outn_ready,
    output logic              data_ready,
    output logic              prev_ready,
    output logic              checkn_start,
    output logic              outn_start,
    output logic [ITER_W-1:0] iter,
    output logic              busy,
    output logic              done,
    output logic              early_exit,
    output logic              timeout_err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_VAR_GO   = 3'd1;
    localparam logic [2:0] S_VAR_WAIT = 3'd2;
    localparam logic [2:0] S_CHK_GO   = 3'd3;
    localparam logic [2:0] S_CHK_WAIT = 3'd4;
    localparam logic [2:0] S_OUT_GO   = 3'd5;
    localparam logic [2:0] S_OUT_WAIT = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER - 1);
    localparam bit                WD_EN     = (TIMEOUT != 0);
    localparam logic [15:0]       WD_LAST   = 16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [15:0]       r_wd;
    logic [ITER_W-1:0] r_iter;
    logic              r_prev;
    logic              r_early;
    logic              r_dr;
    logic              r_cs;
    logic              r_os;
    logic              r_busy;
    logic              r_done;
    logic              r_to;

    logic [2:0]        w_nxt;
    logic [ITER_W-1:0] w_iter;
    logic              w_prev;
    logic              w_early;
    logic              w_to;
    logic              w_wait;
    logic              w_expire;

    assign w_wait = (r_state == S_VAR_WAIT) ||
                    (r_state == S_CHK_WAIT) ||
                    (r_state == S_OUT_WAIT);
    assign w_expire = WD_EN && w_wait && (r_wd == WD_LAST);

    // Abort beats ready and watchdog; ready beats watchdog on the expiry cycle.
    always_comb begin
        w_nxt   = r_state;
        w_iter  = r_iter;
        w_prev  = r_prev;
        w_early = r_early;
        w_to    = 1'b0;
        if (abort && (r_state != S_IDLE)) begin
            w_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_nxt   = S_VAR_GO;
                        w_iter  = '0;
                        w_prev  = 1'b0;
                        w_early = 1'b0;
                    end
                end
                S_VAR_GO: w_nxt = S_VAR_WAIT;
                S_VAR_WAIT: begin
                    if (varn_ready) begin
                        w_nxt = S_CHK_GO;
                    end else if (w_expire) begin
                        w_nxt = S_IDLE;
                        w_to  = 1'b1;
                    end
                end
                S_CHK_GO: w_nxt = S_CHK_WAIT;
                S_CHK_WAIT: begin
                    if (checkn_ready) begin
                        if (EARLY_TERM && syndrome_ok) begin
                            w_early = 1'b1;
                            w_nxt   = S_OUT_GO;
                        end else if (r_iter == LAST_ITER) begin
                            w_nxt = S_OUT_GO;
                        end else begin
                            w_iter = r_iter + ITER_W'(1);
                            w_prev = 1'b1;
                            w_nxt  = S_VAR_GO;
                        end
                    end else if (w_expire) begin
                        w_nxt = S_IDLE;
                        w_to  = 1'b1;
                    end
                end
                S_OUT_GO: w_nxt = S_OUT_WAIT;
                S_OUT_WAIT: begin
                    if (outn_ready) begin
                        w_nxt = S_DONE;
                    end else if (w_expire) begin
                        w_nxt = S_IDLE;
                        w_to  = 1'b1;
                    end
                end
                S_DONE:  w_nxt = S_IDLE;
                default: w_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_wd    <= '0;
            r_iter  <= '0;
            r_prev  <= 1'b0;
            r_early <= 1'b0;
            r_dr    <= 1'b0;
            r_cs    <= 1'b0;
            r_os    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_iter  <= w_iter;
            r_prev  <= w_prev;
            r_early <= w_early;
            if (w_nxt != r_state) begin
                r_wd <= '0;
            end else if (w_wait) begin
                r_wd <= r_wd + 16'd1;
            end
            r_dr   <= (w_nxt == S_VAR_GO);
            r_cs   <= (w_nxt == S_CHK_GO);
            r_os   <= (w_nxt == S_OUT_GO);
            r_busy <= (w_nxt != S_IDLE);
            r_done <= (w_nxt == S_DONE);
            r_to   <= w_to;
        end
    end

    assign data_ready   = r_dr;
    assign prev_ready   = r_prev;
    assign checkn_start = r_cs;
    assign outn_start   = r_os;
    assign iter         = r_iter;
    assign busy         = r_busy;
    assign done         = r_done;
    assign early_exit   = r_early;
    assign timeout_err  = r_to;

endmodule

// File: tb/tb_decoder_iteration_scheduler.sv
// Directed bench for decoder_iteration_scheduler: full runs, early exit,
// watchdog, abort, stray inputs and asynchronous reset.
module tb_decoder_iteration_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       varn_ready;
    logic       checkn_ready;
    logic       syndrome_ok;
    logic       outn_ready;
    logic       data_ready;
    logic       prev_ready;
    logic       checkn_start;
    logic       outn_start;
    logic [2:0] iter;
    logic       busy;
    logic       done;
    logic       early_exit;
    logic       timeout_err;

    int n_chk  = 0;
    int n_fail = 0;
    int c_dr   = 0;
    int c_cs   = 0;
    int c_os   = 0;
    int c_done = 0;
    int c_to   = 0;
    int s_dr, s_cs, s_os, s_done, s_to;

    decoder_iteration_scheduler #(
        .MAX_ITER  (3),
        .ITER_W    (3),
        .EARLY_TERM(1'b1),
        .TIMEOUT   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .varn_ready  (varn_ready),
        .checkn_ready(checkn_ready),
        .syndrome_ok (syndrome_ok),
        .outn_ready  (outn_ready),
        .data_ready  (data_ready),
        .prev_ready  (prev_ready),
        .checkn_start(checkn_start),
        .outn_start  (outn_start),
        .iter        (iter),
        .busy        (busy),
        .done        (done),
        .early_exit  (early_exit),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_ready)   c_dr   <= c_dr + 1;
        if (checkn_start) c_cs   <= c_cs + 1;
        if (outn_start)   c_os   <= c_os + 1;
        if (done)         c_done <= c_done + 1;
        if (timeout_err)  c_to   <= c_to + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic snap;
        s_dr   = c_dr;
        s_cs   = c_cs;
        s_os   = c_os;
        s_done = c_done;
        s_to   = c_to;
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return data_ready;
            1:       return checkn_start;
            2:       return outn_start;
            3:       return done;
            default: return timeout_err;
        endcase
    endfunction

    task automatic wait_sig(input int w, input string tag);
        for (int n = 0; n < 40; n++) begin
            if (sig(w)) break;
            tick();
        end
        check(tag, 32'(sig(w)), 1);
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_dr", 32'(data_ready), 1);
        check("start_busy", 32'(busy), 1);
    endtask

    // Expects to sit on a data_ready cycle; answers the VN layer after 4 cycles.
    task automatic do_var(input int k);
        wait_sig(0, "dr_seen");
        check("dr_iter", 32'(iter), 32'(k));
        check("dr_prev", 32'(prev_ready), 32'(k > 0));
        ticks(4);
        varn_ready = 1'b1;
        tick();
        varn_ready = 1'b0;
        check("cs_after_vr", 32'(checkn_start), 1);
    endtask

    task automatic do_chk(input bit syn, input bit exp_out);
        ticks(4);
        checkn_ready = 1'b1;
        syndrome_ok  = syn;
        tick();
        checkn_ready = 1'b0;
        syndrome_ok  = 1'b0;
        check("os_after_cr", 32'(outn_start), 32'(exp_out));
        check("dr_after_cr", 32'(data_ready), 32'(!exp_out));
    endtask

    task automatic do_out;
        ticks(4);
        outn_ready = 1'b1;
        tick();
        outn_ready = 1'b0;
        check("done_after_or", 32'(done), 1);
        tick();
        check("done_one_cycle", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        varn_ready   = 1'b0;
        checkn_ready = 1'b0;
        syndrome_ok  = 1'b0;
        outn_ready   = 1'b0;
        #3;
        check("rst_outs", 32'({data_ready, prev_ready, checkn_start, outn_start,
                               iter, busy, done, early_exit, timeout_err}), 0);
        ticks(2);
        rst = 1'b1;
        ticks(2);
        check("idle_busy_0", 32'(busy), 0);

        // Full three-iteration run, no early exit
        snap();
        do_start();
        do_var(0);
        do_chk(1'b0, 1'b0);
        do_var(1);
        do_chk(1'b0, 1'b0);
        do_var(2);
        do_chk(1'b0, 1'b1);
        check("full_early", 32'(early_exit), 0);
        do_out();
        check("full_dr_cnt", 32'(c_dr - s_dr), 3);
        check("full_cs_cnt", 32'(c_cs - s_cs), 3);
        check("full_os_cnt", 32'(c_os - s_os), 1);
        check("full_done_cnt", 32'(c_done - s_done), 1);
        check("full_iter_hold", 32'(iter), 2);
        check("full_prev_hold", 32'(prev_ready), 1);

        // Early termination on the first check layer
        snap();
        do_start();
        check("et_early_clr", 32'(early_exit), 0);
        do_var(0);
        do_chk(1'b1, 1'b1);
        check("et_early", 32'(early_exit), 1);
        check("et_iter", 32'(iter), 0);
        do_out();
        check("et_dr_cnt", 32'(c_dr - s_dr), 1);
        check("et_early_hold", 32'(early_exit), 1);

        // Watchdog expiry in VAR_WAIT of iteration 1
        snap();
        do_start();
        do_var(0);
        do_chk(1'b0, 1'b0);
        check("to_iter1", 32'(iter), 1);
        ticks(8);
        check("to_not_yet", 32'(timeout_err), 0);
        check("to_busy_pre", 32'(busy), 1);
        tick();
        check("to_pulse", 32'(timeout_err), 1);
        check("to_busy_post", 32'(busy), 0);
        tick();
        check("to_one_cycle", 32'(timeout_err), 0);
        check("to_no_done", 32'(c_done - s_done), 0);
        check("to_cnt", 32'(c_to - s_to), 1);
        do_start();
        check("to_relaunch_iter", 32'(iter), 0);
        check("to_relaunch_prev", 32'(prev_ready), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_vgo_busy", 32'(busy), 0);

        // Abort colliding with checkn_ready in iteration 1
        do_start();
        do_var(0);
        do_chk(1'b0, 1'b0);
        do_var(1);
        ticks(4);
        snap();
        abort        = 1'b1;
        checkn_ready = 1'b1;
        tick();
        abort        = 1'b0;
        checkn_ready = 1'b0;
        check("ab_busy", 32'(busy), 0);
        check("ab_dr", 32'(data_ready), 0);
        check("ab_iter", 32'(iter), 1);
        ticks(3);
        check("ab_dr_cnt", 32'(c_dr - s_dr), 0);
        check("ab_cs_cnt", 32'(c_cs - s_cs), 0);
        check("ab_os_cnt", 32'(c_os - s_os), 0);
        check("ab_done_cnt", 32'(c_done - s_done), 0);
        check("ab_to_cnt", 32'(c_to - s_to), 0);

        // Start held high while busy, stray checkn_ready in VAR_WAIT
        snap();
        start = 1'b1;
        tick();
        check("held_dr", 32'(data_ready), 1);
        ticks(2);
        checkn_ready = 1'b1;
        syndrome_ok  = 1'b1;
        tick();
        checkn_ready = 1'b0;
        syndrome_ok  = 1'b0;
        check("stray_cs", 32'(checkn_start), 0);
        check("stray_busy", 32'(busy), 1);
        tick();
        varn_ready = 1'b1;
        tick();
        varn_ready = 1'b0;
        check("held_cs", 32'(checkn_start), 1);
        do_chk(1'b0, 1'b0);
        do_var(1);
        do_chk(1'b0, 1'b0);
        do_var(2);
        do_chk(1'b0, 1'b1);
        start = 1'b0;
        do_out();
        check("held_dr_cnt", 32'(c_dr - s_dr), 3);
        check("held_done_cnt", 32'(c_done - s_done), 1);
        check("held_early", 32'(early_exit), 0);

        // Asynchronous reset during OUT_WAIT
        snap();
        do_start();
        do_var(0);
        do_chk(1'b0, 1'b0);
        do_var(1);
        do_chk(1'b0, 1'b0);
        do_var(2);
        do_chk(1'b0, 1'b1);
        ticks(2);
        check("pre_rst_iter", 32'(iter), 2);
        #2;
        rst = 1'b0;
        #1;
        check("arst_outs", 32'({data_ready, prev_ready, checkn_start, outn_start,
                                iter, busy, done, early_exit, timeout_err}), 0);
        tick();
        rst = 1'b1;
        tick();
        outn_ready = 1'b1;
        tick();
        outn_ready = 1'b0;
        ticks(3);
        check("arst_no_done", 32'(c_done - s_done), 0);
        check("arst_busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
